// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 Hz raster constants and decode helpers,
// shared by the sync generator and the downstream colour logic.
package vga_timing_pkg;

    // Coordinate width shared with the colour logic.
    localparam int COORD_W = 10;
    localparam int FCNT_W  = 16;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [FCNT_W-1:0]  fcnt_t;

    // Horizontal timing, in pixels.
    localparam coord_t H_TOTAL     = coord_t'(800);
    localparam coord_t H_LAST      = coord_t'(799);
    localparam coord_t H_SYNC_END  = coord_t'(96);
    localparam coord_t H_ACT_START = coord_t'(144);
    localparam coord_t H_ACT_END   = coord_t'(783);

    // Vertical timing, in lines.
    localparam coord_t V_TOTAL     = coord_t'(525);
    localparam coord_t V_LAST      = coord_t'(524);
    localparam coord_t V_SYNC_END  = coord_t'(2);
    localparam coord_t V_ACT_START = coord_t'(35);
    localparam coord_t V_ACT_END   = coord_t'(514);

    function automatic logic in_span(
        input coord_t x,
        input coord_t lo,
        input coord_t hi
    );
        return (x >= lo) && (x <= hi);
    endfunction

    function automatic logic is_visible(
        input coord_t h,
        input coord_t v
    );
        return in_span(h, H_ACT_START, H_ACT_END) &&
               in_span(v, V_ACT_START, V_ACT_END);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster bundle from the sync generator (master)
// to the colour logic / pins (slave).
// Signals: hCount, vCount, bright, hSync, vSync, pix_en,
//          frame_start, frame_count.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    coord_t hCount;
    coord_t vCount;
    logic   bright;
    logic   hSync;
    logic   vSync;
    logic   pix_en;
    logic   frame_start;
    fcnt_t  frame_count;

    modport master (
        output hCount,
        output vCount,
        output bright,
        output hSync,
        output vSync,
        output pix_en,
        output frame_start,
        output frame_count
    );

    modport slave (
        input hCount,
        input vCount,
        input bright,
        input hSync,
        input vSync,
        input pix_en,
        input frame_start,
        input frame_count
    );

endinterface

// File: rtl/vga_pix_en.sv
// vga_pix_en: board-clock divider producing the one-clk pixel strobe.
// Ports: clk, rst (async, active high) in; pix_en_o out.
module vga_pix_en #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en_o
);

    // A 1-bit counter is kept even for CLK_DIV=1; it then never
    // leaves 0 and the strobe is permanently high.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign pix_en_o = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 Hz raster counters, registered sync/bright
// decode and frame pulse. Ports: clk, rst (async, active high) in;
// vga (vga_sync_gen_if.master) out. Define VGA_SYNC_FRAME_CNT_EN to
// build the 16-bit completed-frame counter; otherwise it reads 0.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic           clk,
    input  logic           rst,
    vga_sync_gen_if.master vga
);

    logic   pix_en;

    coord_t h_q;
    coord_t h_d;
    coord_t v_q;
    coord_t v_d;
    logic   hs_q;
    logic   hs_d;
    logic   vs_q;
    logic   vs_d;
    logic   bright_q;
    logic   bright_d;
    logic   fs_q;
    logic   fs_d;

    vga_pix_en #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_en (
        .clk      (clk),
        .rst      (rst),
        .pix_en_o (pix_en)
    );

    always_comb begin
        h_d  = h_q;
        v_d  = v_q;
        fs_d = 1'b0;
        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d  = '0;
                    fs_d = 1'b1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        // Decode from next-state values so the registered pins line
        // up with the counters they are presented alongside.
        hs_d     = (h_d >= H_SYNC_END);
        vs_d     = (v_d >= V_SYNC_END);
        bright_d = is_visible(h_d, v_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q      <= '0;
            v_q      <= '0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            bright_q <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            bright_q <= bright_d;
            fs_q     <= fs_d;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    fcnt_t fcnt_q;
    fcnt_t fcnt_d;

    // Counts on the same edge that raises frame_start, so the new
    // count is visible together with the pulse.
    always_comb begin
        fcnt_d = fcnt_q;
        if (fs_d) begin
            fcnt_d = fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign vga.frame_count = fcnt_q;
`else
    assign vga.frame_count = '0;
`endif

    assign vga.hCount      = h_q;
    assign vga.vCount      = v_q;
    assign vga.hSync       = hs_q;
    assign vga.vSync       = vs_q;
    assign vga.bright      = bright_q;
    assign vga.pix_en      = pix_en;
    assign vga.frame_start = fs_q;

endmodule
